// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter that shares the write port of a single synchronous FIFO
// among NUM_REQ valid/ready producers. One producer is granted at a time for
// a burst of up to BURST_LEN words. The grant is then released and the search
// for the next winner starts just above the previous winner.
//
// Every release costs one idle bubble cycle. The FIFO is never written while
// it reports full. During a full stall the grant is held and the beat count
// is frozen.
//
// Optional feature (compile-time macro FIFO_ARB_STATS_EN):
//   When defined, the arbiter keeps one saturating counter per requester of
//   accepted words. stat_clr_i clears the counters synchronously, and a clear
//   wins over a simultaneous increment. When undefined, stat_cnt_o is tied to
//   zero, stat_clr_i is ignored and no counter flops are built.
//
// Parameters:
//   DATA_WIDTH  width of one word (must match the FIFO)
//   NUM_REQ     number of requesters, 2..16
//   BURST_LEN   maximum words per grant, >= 1
//   CNT_WIDTH   width of each statistics counter
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   req_valid_i     per-requester word valid
//   req_data_i      packed words, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i      per-requester end-of-burst marker (qualified by valid)
//   req_ready_o     per-requester accept
//   fifo_full_i     FIFO full flag
//   fifo_write_o    FIFO write strobe
//   fifo_wr_data_o  FIFO write data (zero when no grant is active)
//   grant_o         one-hot current grant, zero when idle
//   busy_o          high while a grant is active
//   stat_clr_i      synchronous clear of the statistics counters
//   stat_cnt_o      packed per-requester accepted-word counters
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_write_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  input  logic                          stat_clr_i,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_cnt_o
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  // beat_cnt only ever holds 0..BURST_LEN-1. The transfer that would reach
  // BURST_LEN releases the grant instead.
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 g_valid;
  logic                 g_last;
  logic [DATA_WIDTH-1:0] g_word;
  logic                 xfer;

  // Walk the candidates from the farthest offset back to the nearest. The
  // last hit is therefore the first valid index above the previous winner,
  // wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] valid,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    sel = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (valid[cand]) sel = cand;
    end
    return sel;
  endfunction

  assign pick_idx = rr_pick(req_valid_i, last_q);

  assign g_valid = req_valid_i[gidx_q];
  assign g_last  = req_last_i[gidx_q];
  assign g_word  = req_data_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_GRANT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // The outputs depend on the registered grant and the live requester and
  // full inputs. This keeps the write strobe and ready in step with
  // fifo_full_i in the same cycle. An asynchronous reset forces ST_IDLE, so
  // the write strobe drops without waiting for a clock edge.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    last_d         = last_q;
    beat_d         = beat_q;
    req_ready_o    = '0;
    fifo_write_o   = 1'b0;
    fifo_wr_data_o = '0;
    xfer           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          state_d = ST_GRANT;
          gidx_d  = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          beat_d  = '0;
        end
      end

      ST_GRANT: begin
        xfer           = g_valid & ~fifo_full_i;
        req_ready_o    = grant_q & {NUM_REQ{~fifo_full_i}};
        fifo_write_o   = xfer;
        fifo_wr_data_o = g_word;

        // A stall (full) with valid still high matches neither branch. In
        // that case the grant and beat count simply hold.
        if (!g_valid || (xfer && (g_last || (beat_q == LAST_BEAT)))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else if (xfer) begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] stat_q;
  logic [NUM_REQ-1:0]                xfer_vec;

  assign xfer_vec = req_valid_i & req_ready_o;

  // Saturating per-requester accepted-word counters. The clear takes
  // priority over any increment in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= '0;
    end else if (stat_clr_i) begin
      stat_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (xfer_vec[k] && (stat_q[k] != {CNT_WIDTH{1'b1}})) begin
          stat_q[k] <= stat_q[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign stat_cnt_o = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_cnt_o      = '0;
`endif

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter sharing the write port of one sync_FIFO_buffer instance among NUM_REQ producers.
- Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a burst of up to BURST_LEN words, then rotates.
- Drives the FIFO write_i/wr_data_i and never writes while the FIFO reports full.

Parameters:
- DATA_WIDTH, 32, width of one word; must match the FIFO.
- NUM_REQ, 4, number of requesters; range 2..16.
- BURST_LEN, 4, maximum words per grant before forced rotation; must be >= 1.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester word valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid.
- req_ready_o  out  NUM_REQ  per-requester accept.
- fifo_full_i  in  1  FIFO full_o.
- fifo_write_o  out  1  to FIFO write_i.
- fifo_wr_data_o  out  DATA_WIDTH  to FIFO wr_data_i.
- grant_o  out  NUM_REQ  one-hot current grant; all zeros when idle.
- busy_o  out  1  high while in GRANT.
- stat_clr_i  in  1  synchronous clear of statistics counters.
- stat_cnt_o  out  NUM_REQ*CNT_WIDTH  per-requester accepted-word counters.

Behaviour:
- Reset values (applied asynchronously): state IDLE, grant_o=0, last_winner=NUM_REQ-1, beat_cnt=0, stat counters=0. Resulting outputs: req_ready_o=0, fifo_write_o=0, fifo_wr_data_o=0, busy_o=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid_i is high, select the first valid index searching from last_winner+1 upward, wrapping modulo NUM_REQ.
  - Register the selection into grant_o, clear beat_cnt, and move to GRANT.
  - Arbitration latency is 1 cycle. No transfer happens in IDLE.
- GRANT, with granted index g:
  - req_ready_o[g] = !fifo_full_i; all other ready bits are 0.
  - fifo_write_o = req_valid_i[g] & !fifo_full_i.
  - fifo_wr_data_o = word g. When not in GRANT, fifo_wr_data_o = 0.
  - Transfer: req_valid_i[g] & req_ready_o[g]. A transfer increments beat_cnt.
- Release from GRANT: on a transfer with req_last_i[g]=1, or on a transfer with beat_cnt==BURST_LEN-1, or in any cycle with req_valid_i[g]=0. On release: last_winner<=g, grant_o<=0, state IDLE.
- Each release costs one idle bubble cycle before the next grant.
- Full stall: while fifo_full_i=1, no transfer occurs, beat_cnt holds, and the grant is held for as long as valid stays high. There is no timeout.
- Invariant: fifo_write_o is never 1 in the same cycle as fifo_full_i=1.
- Invariant: grant_o is one-hot or zero, and changes only on clock edges.
- Fairness: a continuously valid requester waits at most (NUM_REQ-1) grants before being served.
- Valid may drop mid-burst without penalty beyond release. A partial burst resumes as a fresh grant later.
- Reset mid-burst: all state clears immediately, the burst is abandoned, and fifo_write_o drops asynchronously.
- Simultaneous valid on all requesters after reset: order is 0,1,2,...,NUM_REQ-1,0,...

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- When defined:
  - stat counter k increments on every transfer from requester k.
  - Counters saturate at 2^CNT_WIDTH-1.
  - stat_clr_i=1 zeroes all counters at the next edge; clear wins over a simultaneous increment.
- When undefined: stat_cnt_o is tied to 0, stat_clr_i is ignored, and no counter flops are built.

Test Plan:
- Single requester, req1 valid for 3 words with last on word 3, FIFO not full -> grant_o=4'b0010 one cycle after valid; 3 consecutive fifo_write_o pulses carrying req1 data; then IDLE.
- All 4 requesters always valid, BURST_LEN=4, last never asserted -> grants rotate 0,1,2,3,0; each grant writes exactly 4 words; 1 bubble cycle between grants.
- req2 granted, fifo_full_i=1 for 5 cycles mid-burst -> fifo_write_o=0 and req_ready_o=0 for those 5 cycles, grant held, beat_cnt frozen; the burst completes after full clears.
- req0 granted, valid dropped after 2 words while req3 is valid -> release; req3 granted next (search starts at 1); req0 later receives a new full 4-word burst.
- rst_i asserted mid-edge-free window during a burst -> grant_o, busy_o, and fifo_write_o go to 0 without a clock; after release, the first grant goes to the lowest valid index.
- With FIFO_ARB_STATS_EN and CNT_WIDTH=4: 20 words from req1 -> stat counter 1 = 15 (saturated); stat_clr_i pulsed during a transfer -> counter reads 0.
